// File: rtl/data_sync_pkg.sv
// rtl/data_sync_pkg.sv - shared constants and parameter checks for the data_sync bus synchronizer
package data_sync_pkg;

  localparam int DS_BUS_WIDTH  = 8;
  localparam int DS_NUM_STAGES = 2;
  localparam int DS_CNT_WIDTH  = 8;

  // Fewer than two flops gives no metastability margin; more than four only adds latency.
  localparam int DS_MIN_STAGES = 2;
  localparam int DS_MAX_STAGES = 4;

  function automatic bit ds_stages_ok(input int n);
    return (n >= DS_MIN_STAGES) && (n <= DS_MAX_STAGES);
  endfunction

endpackage

// File: rtl/ds_pulse_gen.sv
// rtl/ds_pulse_gen.sv - multi-flop enable synchronizer with rising-edge capture strobe
module ds_pulse_gen
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = DS_NUM_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable,
  output logic cap
);

  logic [NUM_STAGES-1:0] en_sync;
  logic                  en_q;
  logic                  en_s;

  if (!ds_stages_ok(NUM_STAGES)) begin : g_bad_stages
    $error("ds_pulse_gen: NUM_STAGES must lie in 2..4");
  end

  // Shift the asynchronous enable through the chain and keep a delayed copy for edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_sync <= '0;
      en_q    <= 1'b0;
    end else begin
      en_sync <= {en_sync[NUM_STAGES-2:0], enable};
      en_q    <= en_s;
    end
  end

  assign en_s = en_sync[NUM_STAGES-1];

  // Only the low-to-high transition of the synchronized level produces a capture,
  // so an enable held high indefinitely yields a single strobe.
  assign cap = en_s & ~en_q;

endmodule

// File: rtl/data_sync.sv
// rtl/data_sync.sv - destination-domain bus synchronizer with valid/ready output and overrun tracking
module data_sync
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = DS_BUS_WIDTH,
  parameter int NUM_STAGES = DS_NUM_STAGES,
  parameter int CNT_WIDTH  = DS_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 SYNC_VALID,
  input  logic                 SYNC_READY,
  output logic                 ENABLE_PULSE,
  output logic                 OVERRUN,
  input  logic                 OVERRUN_CLR,
  output logic [CNT_WIDTH-1:0] DROP_COUNT
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic cap;
  logic drain;
  logic accept;
  logic drop;

  // Only the enable crosses through flops; the bus is sampled once, on cap, while the
  // source holds it stable.
  ds_pulse_gen #(
    .NUM_STAGES(NUM_STAGES)
  ) u_pulse_gen (
    .CLK   (CLK),
    .RST   (RST),
    .enable(BUS_ENABLE),
    .cap   (cap)
  );

  // A capture is taken when the holding register is empty or being drained this same edge.
  assign drain  = SYNC_VALID & SYNC_READY;
  assign accept = cap & (~SYNC_VALID | SYNC_READY);
  assign drop   = cap & SYNC_VALID & ~SYNC_READY;

  // Holding register and valid flag; a simultaneous drain and capture reloads without a bubble.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SYNC_BUS   <= '0;
      SYNC_VALID <= 1'b0;
    end else if (accept) begin
      SYNC_BUS   <= UNSYNC_BUS;
      SYNC_VALID <= 1'b1;
    end else if (drain) begin
      SYNC_VALID <= 1'b0;
    end
  end

  // One-cycle strobe marking each accepted word; dropped words never pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ENABLE_PULSE <= 1'b0;
    end else begin
      ENABLE_PULSE <= accept;
    end
  end

  // Sticky overrun flag; a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVERRUN <= 1'b0;
    end else if (drop) begin
      OVERRUN <= 1'b1;
    end else if (OVERRUN_CLR) begin
      OVERRUN <= 1'b0;
    end
  end

  // Saturating drop counter, cleared only by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DROP_COUNT <= '0;
    end else if (drop && (DROP_COUNT != CNT_MAX)) begin
      DROP_COUNT <= DROP_COUNT + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_data_sync.sv
// tb/tb_data_sync.sv - directed table-driven bench for data_sync
module tb_data_sync;

  logic       CLK;
  logic       RST;
  logic [7:0] UNSYNC_BUS;
  logic       BUS_ENABLE;
  logic [7:0] SYNC_BUS;
  logic       SYNC_VALID;
  logic       SYNC_READY;
  logic       ENABLE_PULSE;
  logic       OVERRUN;
  logic       OVERRUN_CLR;
  logic [7:0] DROP_COUNT;

  int total;
  int bad;

  typedef struct {
    logic [7:0] word;
    logic       rdy_cap;
    logic       rdy_rest;
    logic       clr_cap;
    logic [7:0] e_bus;
    logic       e_valid;
    logic       e_ovr;
    logic [7:0] e_drop;
    int         e_pulses;
  } rec_t;

  rec_t vec[7];

  data_sync #(
    .BUS_WIDTH (8),
    .NUM_STAGES(2),
    .CNT_WIDTH (8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .UNSYNC_BUS  (UNSYNC_BUS),
    .BUS_ENABLE  (BUS_ENABLE),
    .SYNC_BUS    (SYNC_BUS),
    .SYNC_VALID  (SYNC_VALID),
    .SYNC_READY  (SYNC_READY),
    .ENABLE_PULSE(ENABLE_PULSE),
    .OVERRUN     (OVERRUN),
    .OVERRUN_CLR (OVERRUN_CLR),
    .DROP_COUNT  (DROP_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One source word: enable high for three periods, then low for four. The capture edge is
  // the third edge; rdy_cap/clr_cap are presented only for that edge, rdy_rest afterwards.
  task automatic txn(input logic [7:0] w, input logic rc, input logic rr, input logic clr,
                     output int pulses);
    pulses      = 0;
    UNSYNC_BUS  = w;
    BUS_ENABLE  = 1'b1;
    SYNC_READY  = 1'b0;
    OVERRUN_CLR = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (ENABLE_PULSE) pulses++;
      if (e == 2) begin
        SYNC_READY  = rc;
        OVERRUN_CLR = clr;
      end
      if (e == 3) begin
        SYNC_READY  = rr;
        OVERRUN_CLR = 1'b0;
        BUS_ENABLE  = 1'b0;
      end
    end
    SYNC_READY = 1'b0;
  endtask

  initial begin
    int p;
    int psum;
    total       = 0;
    bad         = 0;
    RST         = 1'b0;
    UNSYNC_BUS  = 8'h00;
    BUS_ENABLE  = 1'b0;
    SYNC_READY  = 1'b0;
    OVERRUN_CLR = 1'b0;

    //                word   rc    rr    clr   bus    valid ovr   drop   pulses
    vec[0] = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'd0, 1};
    vec[1] = '{8'h33, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 8'd0, 1};
    vec[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 8'd1, 0};
    vec[3] = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 8'd1, 1};
    vec[4] = '{8'h22, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 8'd2, 0};
    vec[5] = '{8'h77, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'd3, 0};
    vec[6] = '{8'h88, 1'b1, 1'b1, 1'b0, 8'h88, 1'b0, 1'b1, 8'd3, 1};

    repeat (2) tick();
    chk("rst_bus", SYNC_BUS, 8'h00);
    chk("rst_valid", SYNC_VALID, 1'b0);
    chk("rst_pulse", ENABLE_PULSE, 1'b0);
    chk("rst_ovr", OVERRUN, 1'b0);
    chk("rst_drop", DROP_COUNT, 8'd0);
    RST = 1'b1;
    tick();

    // First word: sampled at edge 1, visible after edge 3.
    UNSYNC_BUS = 8'hA5;
    BUS_ENABLE = 1'b1;
    tick();
    chk("lat_e1_valid", SYNC_VALID, 1'b0);
    tick();
    chk("lat_e2_valid", SYNC_VALID, 1'b0);
    chk("lat_e2_pulse", ENABLE_PULSE, 1'b0);
    tick();
    chk("lat_e3_bus", SYNC_BUS, 8'hA5);
    chk("lat_e3_valid", SYNC_VALID, 1'b1);
    chk("lat_e3_pulse", ENABLE_PULSE, 1'b1);
    BUS_ENABLE = 1'b0;
    tick();
    chk("lat_e4_pulse", ENABLE_PULSE, 1'b0);
    chk("lat_e4_valid", SYNC_VALID, 1'b1);
    SYNC_READY = 1'b1;
    tick();
    chk("drain_valid", SYNC_VALID, 1'b0);
    chk("drain_bus", SYNC_BUS, 8'hA5);
    SYNC_READY = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) begin
      txn(vec[i].word, vec[i].rdy_cap, vec[i].rdy_rest, vec[i].clr_cap, p);
      chk($sformatf("v%0d_bus", i), SYNC_BUS, vec[i].e_bus);
      chk($sformatf("v%0d_valid", i), SYNC_VALID, vec[i].e_valid);
      chk($sformatf("v%0d_ovr", i), OVERRUN, vec[i].e_ovr);
      chk($sformatf("v%0d_drop", i), DROP_COUNT, vec[i].e_drop);
      chk($sformatf("v%0d_pulses", i), p, vec[i].e_pulses);
    end

    // Clear alone removes the flag but leaves the count.
    OVERRUN_CLR = 1'b1;
    tick();
    OVERRUN_CLR = 1'b0;
    chk("clr_ovr", OVERRUN, 1'b0);
    chk("clr_drop", DROP_COUNT, 8'd3);

    // Fill the holding register, then drop 300 words to saturate the counter.
    txn(8'h99, 1'b0, 1'b0, 1'b0, p);
    chk("sat_fill_valid", SYNC_VALID, 1'b1);
    psum = 0;
    for (int i = 1; i <= 300; i++) begin
      txn(8'(i), 1'b0, 1'b0, 1'b0, p);
      psum += p;
      if (i == 251) chk("sat_pre", DROP_COUNT, 8'hFE);
    end
    chk("sat_drop", DROP_COUNT, 8'hFF);
    chk("sat_bus", SYNC_BUS, 8'h99);
    chk("sat_pulses", psum, 0);
    chk("sat_ovr", OVERRUN, 1'b1);

    // Reset while a new enable is in the chain, released with the enable still high.
    UNSYNC_BUS = 8'hC3;
    BUS_ENABLE = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("arst_bus", SYNC_BUS, 8'h00);
    chk("arst_valid", SYNC_VALID, 1'b0);
    chk("arst_pulse", ENABLE_PULSE, 1'b0);
    chk("arst_ovr", OVERRUN, 1'b0);
    chk("arst_drop", DROP_COUNT, 8'd0);
    tick();
    chk("arst_hold_valid", SYNC_VALID, 1'b0);
    RST = 1'b1;
    psum = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (ENABLE_PULSE) psum++;
      if (e == 1) chk("rel_e1_valid", SYNC_VALID, 1'b0);
    end
    chk("rel_pulses", psum, 1);
    chk("rel_bus", SYNC_BUS, 8'hC3);
    chk("rel_valid", SYNC_VALID, 1'b1);
    chk("rel_drop", DROP_COUNT, 8'd0);
    BUS_ENABLE = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_sync.md
Name: data_sync

Overview:
- Destination-domain bus synchronizer. It accepts a multi-bit data bus plus a level enable, both from an asynchronous source clock domain.
- The enable passes through a multi-flop chain and is converted to a single-cycle pulse. That pulse captures the quasi-static bus into a holding register.
- The captured word is offered downstream on a valid/ready handshake, with overrun detection.
- Sits between any cross-domain producer (e.g. register file, UART RX) and its consumer in the CLK domain.

Parameters:
- BUS_WIDTH, 8: width of data bus.
- NUM_STAGES, 2: synchronizer flops on the enable path; legal range 2..4.
- CNT_WIDTH, 8: width of the saturating drop counter.

Ports:
- CLK  input  1  destination clock.
- RST  input  1  reset, asynchronous, active-low.
- UNSYNC_BUS  input  BUS_WIDTH  source-domain data; source guarantees it is stable while BUS_ENABLE is high.
- BUS_ENABLE  input  1  source-domain level enable; a rising edge marks a new word.
- SYNC_BUS  output  BUS_WIDTH  captured word, registered.
- SYNC_VALID  output  1  SYNC_BUS holds an unconsumed word.
- SYNC_READY  input  1  consumer accepts the word when SYNC_VALID & SYNC_READY at a CLK edge.
- ENABLE_PULSE  output  1  one-cycle registered strobe coincident with each accepted capture.
- OVERRUN  output  1  sticky; a word arrived while the holding register was full and not being drained.
- OVERRUN_CLR  input  1  synchronous clear of OVERRUN.
- DROP_COUNT  output  CNT_WIDTH  saturating count of dropped words.

Behaviour:
- Reset (RST low, async): the following all go to 0 immediately.
  - Sync chain, pulse flop, SYNC_BUS, SYNC_VALID, ENABLE_PULSE, OVERRUN, DROP_COUNT.
- Enable chain: en_sync[0] <= BUS_ENABLE; en_sync[i] <= en_sync[i-1]. The last stage is the synchronized enable en_s.
- Pulse: en_q <= en_s. Internal capture strobe cap = en_s & ~en_q (rising edge only).
- Latency: BUS_ENABLE first sampled high at edge k gives cap high in the cycle after edge k+NUM_STAGES-1. SYNC_BUS, SYNC_VALID and ENABLE_PULSE update at edge k+NUM_STAGES.
  - Example: NUM_STAGES=2 gives outputs 2 edges after first sample.
- Capture at an edge with cap=1:
  - Accept if SYNC_VALID=0 or SYNC_READY=1. Then SYNC_BUS <= UNSYNC_BUS, SYNC_VALID <= 1, ENABLE_PULSE <= 1.
  - Otherwise drop. SYNC_BUS and SYNC_VALID are unchanged, ENABLE_PULSE <= 0, OVERRUN <= 1, and DROP_COUNT increments, saturating at all-ones.
- Drain without capture: if SYNC_VALID & SYNC_READY and cap=0, then SYNC_VALID <= 0. SYNC_BUS holds its last value and never returns to 0 except on reset.
- Simultaneous drain and capture: the new word loads and SYNC_VALID stays 1; this costs no bubble.
- ENABLE_PULSE is 0 on every cycle without an accepted capture, so it is exactly one cycle wide per word.
- OVERRUN_CLR with a simultaneous drop: set wins, so OVERRUN stays 1. OVERRUN_CLR does not clear DROP_COUNT; only reset does.
- BUS_ENABLE held high indefinitely produces exactly one capture. No retrigger occurs until BUS_ENABLE has been low and then high again.
- Source timing constraints:
  - BUS_ENABLE high ≥ NUM_STAGES+1 CLK periods and low ≥ NUM_STAGES+1 CLK periods.
  - UNSYNC_BUS stable from BUS_ENABLE rise until fall.
  - Shorter pulses may be missed or merged. This is permitted, undetected behaviour and not an error.
- Reset released while BUS_ENABLE is already high: the chain fills from 0, a rising edge is seen, and one capture occurs NUM_STAGES edges after release.
- Reset asserted mid-transfer: the in-flight word is discarded and the handshake restarts clean.
- The enable is the only signal sent through synchronizer flops. The data bus is never multi-flopped; it is captured only on cap.

Decomposition:
- Shared package data_sync_pkg holds:
  - default constants DS_BUS_WIDTH=8, DS_NUM_STAGES=2, DS_CNT_WIDTH=8;
  - a NUM_STAGES range check constant/assertion helper.
- One sub-module, ds_pulse_gen, contains the NUM_STAGES-deep 1-bit sync chain plus the rising-edge detector, with output cap.
- Top level holds the capture register, handshake, overrun and counter logic.

Test Plan:
- Reset, then BUS_ENABLE=1 with UNSYNC_BUS=0xA5 at edge 1, SYNC_READY=0, NUM_STAGES=2 -> SYNC_BUS=0xA5, SYNC_VALID=1 and ENABLE_PULSE=1 after edge 3. ENABLE_PULSE=0 after edge 4, and SYNC_VALID remains 1.
- SYNC_READY=1 one cycle after the capture above -> SYNC_VALID=0 after the next edge, SYNC_BUS still 0xA5.
- Word 0x11 held unconsumed (SYNC_READY=0), second enable with 0x22 -> SYNC_BUS stays 0x11, OVERRUN=1, DROP_COUNT=1, ENABLE_PULSE never high for 0x22.
- SYNC_VALID=1 with SYNC_READY=1 on the same edge the 0x33 capture fires -> SYNC_BUS=0x33, SYNC_VALID stays 1, OVERRUN stays 0.
- OVERRUN=1, then OVERRUN_CLR on a cycle with a simultaneous drop -> OVERRUN stays 1 and DROP_COUNT increments. OVERRUN_CLR alone next cycle -> OVERRUN=0, DROP_COUNT unchanged.
- Force 300 drops (CNT_WIDTH=8) -> DROP_COUNT saturates at 0xFF.
- RST pulsed low while the enable is in the chain -> all outputs 0 immediately. If BUS_ENABLE is still high at release, exactly one capture occurs NUM_STAGES edges after release.
